label_merger: RTL
=================

Name: label_merger

Overview:
- Equivalence-table stage directly downstream of the connected-component labeler.
- During a frame it captures every merge request (merge_b equivalent to merge_a) and tracks the highest label allocated.
- After the frame's last pixel it resolves all equivalences with union-find, then flattens the table so every label maps straight to its root (smallest equivalent label).
- The bounding-box stage reads resolved roots through a registered query port.

Parameters:
- LABEL_WIDTH, 8, label bit width; table holds 2^LABEL_WIDTH entries, label 0 = background.
- MERGE_DEPTH, 64, merge-pair FIFO depth (power of 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  pixel-stream qualifier (same as labeler enable)
- last_in_frame  in  1  final pixel of frame, qualified by enable
- new_label_valid  in  1  labeler allocated a label this cycle
- new_label_value  in  LABEL_WIDTH  allocated label
- merge_labels  in  1  merge request
- merge_a  in  LABEL_WIDTH  surviving (smaller) label
- merge_b  in  LABEL_WIDTH  label merged into merge_a
- resolve_ack  in  1  consumer done querying; pulse re-arms the block
- busy  out  1  high in INIT, RESOLVE_POP, FIND_A, FIND_B, LINK, FLATTEN
- table_ready  out  1  high only in DONE
- max_label  out  LABEL_WIDTH  highest label allocated in the completed frame
- query_label  in  LABEL_WIDTH  label to resolve
- query_root  out  LABEL_WIDTH  root of query_label, registered, 1-cycle latency
- overflow  out  1  sticky: merge dropped (FIFO full or not in COLLECT); cleared on INIT entry

Behaviour:
- Reset: state=INIT, init index=0, parent[] undefined until INIT completes, busy=1, table_ready=0, max_label=0, query_root=0, overflow=0, FIFO empty.
- INIT:
  - Writes parent[i]=i for i=0..2^LW-1, one entry per cycle, so it takes 2^LW cycles.
  - Clears overflow and max_label.
  - Then enters COLLECT.
- COLLECT:
  - When enable&&new_label_valid: max_label <= max(max_label, new_label_value).
  - When enable&&merge_labels: pushes (merge_a, merge_b) if not full, otherwise sets overflow.
  - Merges with merge_a==merge_b or either label 0 are ignored, not pushed.
  - When enable&&last_in_frame: any merge/new label in that same cycle is captured first, then the state goes to RESOLVE_POP.
- RESOLVE_POP:
  - If FIFO empty, goes to FLATTEN with index=1.
  - Otherwise pops a pair: x<=a, y<=b, then FIND_A.
- FIND_A:
  - If parent[x]==x, goes to FIND_B.
  - Otherwise x<=parent[x]; one hop per cycle.
- FIND_B: same walk on y, then LINK.
- LINK:
  - If x<y, parent[y]<=x; if y<x, parent[x]<=y; if equal, no write.
  - Then RESOLVE_POP.
  - Invariant: parent[i]<=i always, so walks terminate.
- FLATTEN:
  - For i=index: parent[i]<=parent[parent[i]]; index++.
  - Ascending order guarantees the parent is already a root, so one pass gives full compression.
  - Ends after i==max_label, or immediately if max_label==0, then goes to DONE.
- DONE:
  - table_ready=1.
  - query_root <= parent[query_label] each cycle; in other states query_root holds its value.
  - On resolve_ack, goes to INIT. resolve_ack outside DONE is ignored.
- Pixels and merges arriving outside COLLECT are dropped. Merges dropped this way set overflow. Last_in_frame outside COLLECT is ignored.
- Async reset mid-resolve: everything returns to reset values and INIT restarts; the partial table is discarded.
- Label arithmetic is unsigned and has no wrap. A merge referencing a label above max_label is still linked; flatten covers only 1..max_label.

Test Plan:
- Reset, wait 256 cycles (LW=8) → busy falls; no merges, last_in_frame → table_ready within 3 cycles, max_label=0, query 5 → root 5.
- Allocate labels 1..4, merges (1,3),(2,4),(1,2), last_in_frame → DONE; queries 1,2,3,4 → 1,1,1,1; max_label=4.
- Chain: allocate 1..5, merges (4,5),(3,4),(2,3),(1,2) → all five query roots =1; query 6 → 6.
- Merge (2,2) and (0,3) → ignored, FIFO empty, query 3 → 3; overflow=0.
- MERGE_DEPTH+1 valid merges in one frame → overflow=1 in DONE; after resolve_ack and INIT, overflow=0.
- Assert rst during FIND_A → next cycle busy=1, table_ready=0, max_label=0; new frame with merge (1,2) → query 2 → 1.

Source files
------------

// File: rtl/label_merger_if.sv
// Bus bundle between the connected-component labeler, the label merger and the
// bounding-box stage that queries resolved roots.
interface label_merger_if #(
   parameter int unsigned LABEL_WIDTH = 8
);
   logic                   enable;
   logic                   last_in_frame;
   logic                   new_label_valid;
   logic [LABEL_WIDTH-1:0] new_label_value;
   logic                   merge_labels;
   logic [LABEL_WIDTH-1:0] merge_a;
   logic [LABEL_WIDTH-1:0] merge_b;
   logic                   resolve_ack;
   logic                   busy;
   logic                   table_ready;
   logic [LABEL_WIDTH-1:0] max_label;
   logic [LABEL_WIDTH-1:0] query_label;
   logic [LABEL_WIDTH-1:0] query_root;
   logic                   overflow;

   // Upstream labeler / downstream consumer side
   modport master (
      output enable, last_in_frame, new_label_valid, new_label_value,
             merge_labels, merge_a, merge_b, resolve_ack, query_label,
      input  busy, table_ready, max_label, query_root, overflow
   );

   // Label merger side
   modport slave (
      input  enable, last_in_frame, new_label_valid, new_label_value,
             merge_labels, merge_a, merge_b, resolve_ack, query_label,
      output busy, table_ready, max_label, query_root, overflow
   );
endinterface

// File: rtl/label_merger.sv
// Equivalence table for connected-component labeling: collects merge pairs
// during a frame, resolves them with union-find after the last pixel, then
// flattens the table so every label points directly at its smallest
// equivalent label. Roots are read back through a registered query port.
module label_merger #(
   parameter int unsigned LABEL_WIDTH = 8,
   parameter int unsigned MERGE_DEPTH = 64
) (
   input logic           clk,
   input logic           rst,
   label_merger_if.slave bus
);
   localparam int unsigned LW  = LABEL_WIDTH;
   localparam int unsigned NUM = 1 << LW;
   localparam int unsigned AW  = $clog2(MERGE_DEPTH);

   typedef enum logic [2:0] {
      S_INIT,
      S_COLLECT,
      S_RESOLVE_POP,
      S_FIND_A,
      S_FIND_B,
      S_LINK,
      S_FLATTEN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic [LW-1:0] r_parent [NUM];
   logic [LW-1:0] r_fifo_a [MERGE_DEPTH];
   logic [LW-1:0] r_fifo_b [MERGE_DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;

   logic [LW-1:0] r_idx;
   logic [LW-1:0] r_x;
   logic [LW-1:0] r_y;
   logic [LW-1:0] r_max_label;
   logic [LW-1:0] r_query_root;
   logic          r_overflow;

   logic          w_in_collect;
   logic          w_merge_valid;
   logic          w_fifo_empty;
   logic          w_fifo_full;
   logic          w_push;
   logic          w_drop;
   logic          w_alloc;
   logic [LW-1:0] w_par_x;
   logic [LW-1:0] w_par_y;
   logic [LW-1:0] w_par_i;
   logic [LW-1:0] w_par_pi;
   logic [LW-1:0] w_par_q;
   logic          w_par_we;
   logic [LW-1:0] w_par_addr;
   logic [LW-1:0] w_par_wdata;

   assign w_in_collect  = (r_state == S_COLLECT);
   // Self-merges and background merges carry no information and are discarded
   assign w_merge_valid = bus.enable && bus.merge_labels &&
                          (bus.merge_a != bus.merge_b) &&
                          (bus.merge_a != '0) && (bus.merge_b != '0);
   assign w_fifo_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_fifo_full   = ((r_wr_ptr - r_rd_ptr) == (AW+1)'(MERGE_DEPTH));
   assign w_push        = w_in_collect && w_merge_valid && !w_fifo_full;
   assign w_drop        = w_merge_valid && (!w_in_collect || w_fifo_full);
   assign w_alloc       = w_in_collect && bus.enable && bus.new_label_valid;

   assign w_par_x  = r_parent[r_x];
   assign w_par_y  = r_parent[r_y];
   assign w_par_i  = r_parent[r_idx];
   assign w_par_pi = r_parent[w_par_i];
   assign w_par_q  = r_parent[bus.query_label];

   assign bus.busy        = (r_state != S_COLLECT) && (r_state != S_DONE);
   assign bus.table_ready = (r_state == S_DONE);
   assign bus.max_label   = r_max_label;
   assign bus.query_root  = r_query_root;
   assign bus.overflow    = r_overflow;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_INIT;
      else     r_state <= w_next_state;
   end

   // Next-state and parent-table write port selection
   always_comb begin
      w_next_state = r_state;
      w_par_we     = 1'b0;
      w_par_addr   = r_idx;
      w_par_wdata  = r_idx;
      case (r_state)
         S_INIT: begin
            w_par_we = 1'b1;
            if (r_idx == '1) w_next_state = S_COLLECT;
         end
         S_COLLECT: begin
            if (bus.enable && bus.last_in_frame) w_next_state = S_RESOLVE_POP;
         end
         S_RESOLVE_POP: begin
            w_next_state = w_fifo_empty ? S_FLATTEN : S_FIND_A;
         end
         S_FIND_A: begin
            if (w_par_x == r_x) w_next_state = S_FIND_B;
         end
         S_FIND_B: begin
            if (w_par_y == r_y) w_next_state = S_LINK;
         end
         S_LINK: begin
            w_next_state = S_RESOLVE_POP;
            // Always hang the larger root under the smaller so parent[i] <= i holds
            if (r_x < r_y) begin
               w_par_we    = 1'b1;
               w_par_addr  = r_y;
               w_par_wdata = r_x;
            end else if (r_y < r_x) begin
               w_par_we    = 1'b1;
               w_par_addr  = r_x;
               w_par_wdata = r_y;
            end
         end
         S_FLATTEN: begin
            if (r_max_label == '0) begin
               w_next_state = S_DONE;
            end else begin
               // Ascending sweep: parent[i] < i is already a root, one hop suffices
               w_par_we    = 1'b1;
               w_par_wdata = w_par_pi;
               if (r_idx == r_max_label) w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.resolve_ack) w_next_state = S_INIT;
         end
         default: w_next_state = S_INIT;
      endcase
   end

   // Control datapath: indices, find cursors, FIFO pointers, status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx        <= '0;
         r_x          <= '0;
         r_y          <= '0;
         r_max_label  <= '0;
         r_query_root <= '0;
         r_overflow   <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
      end else begin
         case (r_state)
            S_INIT: r_idx <= r_idx + LW'(1);
            S_RESOLVE_POP: begin
               if (w_fifo_empty) begin
                  r_idx <= LW'(1);
               end else begin
                  r_x      <= r_fifo_a[r_rd_ptr[AW-1:0]];
                  r_y      <= r_fifo_b[r_rd_ptr[AW-1:0]];
                  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
               end
            end
            S_FIND_A: if (w_par_x != r_x) r_x <= w_par_x;
            S_FIND_B: if (w_par_y != r_y) r_y <= w_par_y;
            S_FLATTEN: r_idx <= r_idx + LW'(1);
            S_DONE: begin
               r_query_root <= w_par_q;
               if (bus.resolve_ack) begin
                  r_idx       <= '0;
                  r_max_label <= '0;
                  r_overflow  <= 1'b0;
               end
            end
            default: ;
         endcase
         if (w_alloc && (bus.new_label_value > r_max_label))
            r_max_label <= bus.new_label_value;
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   // Merge-pair FIFO storage
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_a[r_wr_ptr[AW-1:0]] <= bus.merge_a;
         r_fifo_b[r_wr_ptr[AW-1:0]] <= bus.merge_b;
      end
   end

   // Parent table storage, single write port
   always_ff @(posedge clk) begin
      if (w_par_we) r_parent[w_par_addr] <= w_par_wdata;
   end
endmodule
